// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS memory-mapped output port.
// Holds the processor data width, the default port address and the checker state encoding.
package mips_pkg;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] PORT_ADR = 8'hFF;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_PASS = 2'd1,
    CHK_FAIL = 2'd2
  } chk_state_t;

endpackage

// File: rtl/mips_out_port_if.sv
// Bus bundle between the processor/consumer side (master) and the output port (slave).
interface mips_out_port_if #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             overflow;

  modport master (
    output memwrite, adr, writedata, out_ready,
    input  out_data, out_valid, count, full, overflow
  );

  modport slave (
    input  memwrite, adr, writedata, out_ready,
    output out_data, out_valid, count, full, overflow
  );
endinterface

// File: rtl/mips_out_fifo.sv
// Circular FIFO behind the output port; a push into a full FIFO is accepted
// only when the same edge pops, otherwise it is dropped and flagged sticky.
module mips_out_fifo #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             overflow
);
  import mips_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  // Head comes from storage only; forced to zero while empty so stale entries never show.
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_out_port.sv
// Memory-mapped output port: decodes processor stores to PORT_ADR into a FIFO.
// Optional first-value checker (pass/fail) is built when MIPS_OUT_PORT_CHECK_EN is defined.
module mips_out_port #(
  parameter int                          WIDTH    = mips_pkg::WIDTH,
  parameter logic [mips_pkg::WIDTH-1:0]  PORT_ADR = mips_pkg::PORT_ADR,
  parameter int                          DEPTH    = 4,
  parameter logic [mips_pkg::WIDTH-1:0]  EXPECT   = 8'h0D
) (
  input  logic            clk,
  input  logic            reset,
`ifdef MIPS_OUT_PORT_CHECK_EN
  output logic            pass,
  output logic            fail,
`endif
  mips_out_port_if.slave  bus
);
  import mips_pkg::*;

  logic port_store;

  assign port_store = bus.memwrite && (bus.adr == PORT_ADR);

  mips_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (port_store),
    .pop      (bus.out_ready),
    .din      (bus.writedata),
    .dout     (bus.out_data),
    .valid    (bus.out_valid),
    .count    (bus.count),
    .full     (bus.full),
    .overflow (bus.overflow)
  );

`ifdef MIPS_OUT_PORT_CHECK_EN
  chk_state_t state;
  logic       push_accepted;

  // Mirrors the FIFO's acceptance rule so a dropped store never moves the checker.
  assign push_accepted = port_store && (!bus.full || (bus.out_valid && bus.out_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CHK_IDLE;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else if (state == CHK_IDLE && push_accepted) begin
      if (bus.writedata == EXPECT) begin
        state <= CHK_PASS;
        pass  <= 1'b1;
      end else begin
        state <= CHK_FAIL;
        fail  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_out_port.sv
// Randomized self-checking bench for mips_out_port against a queue-based model.
// pass/fail checks are compiled only when MIPS_OUT_PORT_CHECK_EN is defined.
module tb_mips_out_port;

  localparam int         WIDTH    = 8;
  localparam int         DEPTH    = 4;
  localparam logic [7:0] PORT_ADR = 8'hFF;
  localparam logic [7:0] EXPECT   = 8'h0D;

  logic clk;
  logic reset;
`ifdef MIPS_OUT_PORT_CHECK_EN
  logic pass;
  logic fail;
`endif

  mips_out_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mips_out_port #(
    .WIDTH    (WIDTH),
    .PORT_ADR (PORT_ADR),
    .DEPTH    (DEPTH),
    .EXPECT   (EXPECT)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MIPS_OUT_PORT_CHECK_EN
    .pass  (pass),
    .fail  (fail),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: contents as a queue, sticky overflow, checker as 0/1/2 (idle/pass/fail).
  logic [7:0] model_q[$];
  bit         model_ovf;
  int         model_chk;

  int n_vec;
  int n_err;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every output is checked against the model each cycle after the edge has settled.
  task automatic checkOutput();
    logic [7:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
    compare("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    compare("out_data",  32'(bus.out_data),  32'(exp_data));
    compare("count",     32'(bus.count),     32'(model_q.size()));
    compare("full",      32'(bus.full),      32'(model_q.size() == DEPTH));
    compare("overflow",  32'(bus.overflow),  32'(model_ovf));
`ifdef MIPS_OUT_PORT_CHECK_EN
    compare("pass", 32'(pass), 32'(model_chk == 1));
    compare("fail", 32'(fail), 32'(model_chk == 2));
`endif
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model, and checks after the edge.
  task automatic applyStimulus(input bit rst, input bit mw, input logic [7:0] a,
                               input logic [7:0] wd, input bit rdy);
    bit port;
    bit pop;
    bit acc;
    reset         = rst;
    bus.memwrite  = mw;
    bus.adr       = a;
    bus.writedata = wd;
    bus.out_ready = rdy;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_chk = 0;
    end else begin
      port = mw && (a == PORT_ADR);
      pop  = rdy && (model_q.size() > 0);
      acc  = port && ((model_q.size() < DEPTH) || pop);
      if (pop) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(wd);
        if (model_chk == 0) model_chk = (wd == EXPECT) ? 1 : 2;
      end else if (port) begin
        model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_ovf = 1'b0;
    model_chk = 0;
    reset = 1'b1;
    bus.memwrite = 1'b0;
    bus.adr = '0;
    bus.writedata = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    repeat (4) applyStimulus(1, 0, 8'h00, 8'h00, 0);
    compare("rst_count", 32'(bus.count), 32'd0);
    compare("rst_data",  32'(bus.out_data), 32'd0);

    // Expected first value, consumer ready: visible one cycle later, popped the cycle after.
    applyStimulus(0, 1, 8'hFF, 8'h0D, 1);
    compare("first_valid", 32'(bus.out_valid), 32'd1);
    compare("first_data",  32'(bus.out_data),  32'h0D);
`ifdef MIPS_OUT_PORT_CHECK_EN
    compare("first_pass", 32'(pass), 32'd1);
    compare("first_fail", 32'(fail), 32'd0);
`endif
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    compare("popped_count", 32'(bus.count), 32'd0);

    // Wrong first value latches fail even after a later correct value.
    applyStimulus(1, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 1, 8'hFF, 8'h0C, 1);
    applyStimulus(0, 1, 8'hFF, 8'h0D, 1);
`ifdef MIPS_OUT_PORT_CHECK_EN
    compare("sticky_fail", 32'(fail), 32'd1);
    compare("sticky_pass", 32'(pass), 32'd0);
`endif

    // Store to a neighbouring address is ignored.
    applyStimulus(1, 0, 8'h00, 8'h00, 0);
    applyStimulus(0, 1, 8'hFE, 8'h0D, 0);
    compare("wrong_adr_count", 32'(bus.count), 32'd0);
`ifdef MIPS_OUT_PORT_CHECK_EN
    compare("wrong_adr_idle", 32'({pass, fail}), 32'd0);
`endif

    // Five stores into a four-deep FIFO with the consumer stalled.
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 8'hFF, 8'(i), 0);
    compare("fill_full",  32'(bus.full),     32'd1);
    compare("fill_count", 32'(bus.count),    32'd4);
    compare("fill_ovf",   32'(bus.overflow), 32'd1);
    compare("fill_head",  32'(bus.out_data), 32'd1);

    // Full with simultaneous push of 9 and pop: count holds, 9 lands at the tail.
    applyStimulus(0, 1, 8'hFF, 8'h09, 1);
    compare("fullpp_count", 32'(bus.count), 32'd4);
    compare("drain_2", 32'(bus.out_data), 32'd2);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    compare("drain_3", 32'(bus.out_data), 32'd3);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    compare("drain_4", 32'(bus.out_data), 32'd4);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    compare("drain_9", 32'(bus.out_data), 32'd9);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);
    compare("drain_empty", 32'(bus.out_valid), 32'd0);
    applyStimulus(0, 0, 8'h00, 8'h00, 1);

    // Reset mid-stream discards three entries and the sticky flag.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, 8'(8'h20 + i), 0);
    compare("pre_rst_count", 32'(bus.count), 32'd3);
    applyStimulus(1, 1, 8'hFF, 8'h55, 1);
    compare("mid_rst_count", 32'(bus.count), 32'd0);
    compare("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    compare("mid_rst_ovf",   32'(bus.overflow), 32'd0);

    // Randomized traffic, biased toward the port address and the expected value.
    for (int i = 0; i < 3000; i++) begin
      bit         r_rst;
      bit         r_mw;
      bit         r_rdy;
      logic [7:0] r_adr;
      logic [7:0] r_wd;
      int         sel;
      r_rst = ($urandom_range(0, 99) == 0);
      r_mw  = ($urandom_range(0, 1) == 1);
      r_rdy = ($urandom_range(0, 2) == 0);
      sel   = $urandom_range(0, 3);
      r_adr = (sel < 2) ? 8'hFF : ((sel == 2) ? 8'hFE : 8'($urandom));
      r_wd  = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
      applyStimulus(r_rst, r_mw, r_adr, r_wd, r_rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
